bk_adder_feeder: RTL and testbench

- Registered handshake harness that sits directly upstream and downstream of the combinational 12-bit Brent-Kung adder netlist.
- Accepts operand pairs on a valid/ready interface and drives them onto the adder's bit-interleaved 24-bit input bus.
- Waits a programmable settle time, then captures the adder's 13-bit result and presents it downstream with valid/ready.
- Self-checks each captured sum against a behavioural a+b and counts mismatches, for evaluating optimized or mapped netlists in place.

---
 rtl/bk_adder_feeder.sv | 167 ++++++++++++++++
 tb/tb_bk_adder_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bk_adder_feeder.sv
// Handshake harness around a combinational Brent-Kung adder netlist.
// Launches operand pairs onto the adder's interleaved input bus, waits a
// programmable number of edges for the netlist to settle, captures the
// result, checks it against a behavioural a+b and presents it downstream.
module bk_adder_feeder #(
    parameter int WIDTH         = 12,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERRW          = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [2*WIDTH-1:0]   adder_in,
    input  logic [WIDTH:0]       adder_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH:0]       out_sum,
    output logic                 out_mismatch,
    output logic [ERRW-1:0]      err_count
);

    // A zero settle time would capture before the netlist ever saw the operands.
    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $fatal(1, "bk_adder_feeder: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    localparam int CNTW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t                 state_r;
    logic [WIDTH-1:0]       a_r;
    logic [WIDTH-1:0]       b_r;
    logic [CNTW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]     adder_in_r;
    logic                   out_valid_r;
    logic [WIDTH:0]         out_sum_r;
    logic                   out_mismatch_r;
    logic [ERRW-1:0]        err_count_r;

    logic                   in_ready_s;
    logic [WIDTH:0]         ref_sum_s;
    logic                   mismatch_s;
    logic                   err_sat_s;

    // Bit-interleave two operands: even bits carry a, odd bits carry b.
    function automatic logic [2*WIDTH-1:0] interleave(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] bus;
        bus = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bus[2*i]     = a[i];
            bus[2*i + 1] = b[i];
        end
        return bus;
    endfunction

    // Zero-extended reference sum; the carry-out lands in bit WIDTH.
    function automatic logic [WIDTH:0] reference_sum(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign ref_sum_s  = reference_sum(a_r, b_r);
    assign mismatch_s = (adder_out != ref_sum_s);
    assign err_sat_s  = (err_count_r == {ERRW{1'b1}});

    // Ready: free when idle, follows downstream when holding so a new pair
    // can be taken on the same edge the current result leaves.
    always_comb begin
        in_ready_s = 1'b0;
        if (!rst_n) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:   in_ready_s = 1'b1;
                ST_HOLD:   in_ready_s = out_ready;
                ST_SETTLE: in_ready_s = 1'b0;
                default:   in_ready_s = 1'b0;
            endcase
        end
    end

    // Control FSM with all datapath registers: launch, settle countdown,
    // capture/self-check and downstream hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            a_r            <= '0;
            b_r            <= '0;
            cnt_r          <= '0;
            adder_in_r     <= '0;
            out_valid_r    <= 1'b0;
            out_sum_r      <= '0;
            out_mismatch_r <= 1'b0;
            err_count_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r        <= in_a;
                        b_r        <= in_b;
                        adder_in_r <= interleave(in_a, in_b);
                        cnt_r      <= CNTW'(SETTLE_CYCLES);
                        state_r    <= ST_SETTLE;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == CNTW'(1)) begin
                        out_sum_r      <= adder_out;
                        out_mismatch_r <= mismatch_s;
                        if (mismatch_s && !err_sat_s) begin
                            err_count_r <= err_count_r + {{(ERRW-1){1'b0}}, 1'b1};
                        end else begin
                            err_count_r <= err_count_r;
                        end
                        out_valid_r    <= 1'b1;
                        cnt_r          <= '0;
                        state_r        <= ST_HOLD;
                    end else begin
                        cnt_r          <= cnt_r - CNTW'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (in_valid) begin
                            a_r        <= in_a;
                            b_r        <= in_b;
                            adder_in_r <= interleave(in_a, in_b);
                            cnt_r      <= CNTW'(SETTLE_CYCLES);
                            state_r    <= ST_SETTLE;
                        end else begin
                            state_r    <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    cnt_r       <= '0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_s;
    assign adder_in     = adder_in_r;
    assign out_valid    = out_valid_r;
    assign out_sum      = out_sum_r;
    assign out_mismatch = out_mismatch_r;
    assign err_count    = err_count_r;

endmodule

// File: tb/tb_bk_adder_feeder.sv
// Self-checking bench for bk_adder_feeder: behavioural adder netlist with
// fault injection, a transaction-level reference model compared every cycle,
// directed literal checks and a randomized scoreboard run.
module tb_bk_adder_feeder;

    localparam int W = 12;
    localparam int S = 2;
    localparam int E = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic [2*W-1:0]  adder_in;
    logic [W:0]      adder_out;
    logic            out_valid;
    logic            out_ready;
    logic [W:0]      out_sum;
    logic            out_mismatch;
    logic [E-1:0]    err_count;

    logic            fault;
    logic [W:0]      fault_val;

    always #5 clk = ~clk;

    bk_adder_feeder #(.WIDTH(W), .SETTLE_CYCLES(S), .ERRW(E)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .adder_in(adder_in), .adder_out(adder_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_mismatch(out_mismatch), .err_count(err_count)
    );

    // Behavioural stand-in for the adder netlist: undo the interleave, add.
    function automatic logic [W:0] netlist_add(input logic [2*W-1:0] bus);
        int a, b;
        a = 0; b = 0;
        for (int i = 0; i < W; i++) begin
            a += int'(bus[2*i]) << i;
            b += int'(bus[2*i+1]) << i;
        end
        return (W+1)'(a + b);
    endfunction

    // Arithmetic form of the interleave: a bit i is worth 4^i, b bit i 2*4^i.
    function automatic logic [2*W-1:0] spread(input logic [W-1:0] a, input logic [W-1:0] b);
        longint v;
        v = 0;
        for (int i = 0; i < W; i++)
            v += (longint'((a >> i) & 1) + 2 * longint'((b >> i) & 1)) * (longint'(1) << (2*i));
        return (2*W)'(v);
    endfunction

    assign adder_out = fault ? fault_val : netlist_add(adder_in);

    // ---------------- reference model (transaction level) ----------------
    bit              armed = 1'b0;
    int              m_left = 0;     // edges until capture, 0 when not settling
    bit              m_hold = 1'b0;  // a captured result is waiting downstream
    logic [W-1:0]    m_a, m_b;
    logic [2*W-1:0]  m_bus;
    logic [W:0]      m_sum;
    bit              m_mis;
    int              m_err;

    wire             mdl_rdy = (m_left == 0 && !m_hold) || (m_hold && out_ready);
    wire [W:0]       mdl_ref = W'(m_a) + (W+1)'(m_b);
    wire [W:0]       mdl_cap = fault ? fault_val : mdl_ref;

    always @(posedge clk) begin
        if (!rst_n) begin
            armed  <= 1'b1;
            m_left <= 0;
            m_hold <= 1'b0;
            m_a    <= '0;
            m_b    <= '0;
            m_bus  <= '0;
            m_sum  <= '0;
            m_mis  <= 1'b0;
            m_err  <= 0;
        end else if (armed) begin
            if (m_left == 1) begin
                m_sum  <= mdl_cap;
                m_mis  <= (mdl_cap != mdl_ref);
                if (mdl_cap != mdl_ref && m_err < 255) m_err <= m_err + 1;
                m_hold <= 1'b1;
                m_left <= 0;
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end
            if (m_hold && out_ready) m_hold <= 1'b0;
            if (in_valid && mdl_rdy) begin
                m_a    <= in_a;
                m_b    <= in_b;
                m_bus  <= spread(in_a, in_b);
                m_left <= S;
            end
        end
    end

    // ---------------- per-cycle compare process ----------------
    int          c_checks = 0;
    int          c_fail   = 0;
    bit          sb_on    = 1'b0;
    int          acc_obs  = 0;
    int          del_obs  = 0;
    logic [W:0]  sb_q[$];

    task automatic ccmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        c_checks++;
        if (act !== exp) begin
            c_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            ccmp("in_ready",     32'(in_ready),     32'(rst_n && mdl_rdy));
            ccmp("out_valid",    32'(out_valid),    32'(m_hold));
            ccmp("adder_in",     32'(adder_in),     32'(m_bus));
            ccmp("out_sum",      32'(out_sum),      32'(m_sum));
            ccmp("out_mismatch", 32'(out_mismatch), 32'(m_mis));
            ccmp("err_count",    32'(err_count),    32'(m_err));
            if (sb_on) begin
                if (out_valid && out_ready) begin
                    del_obs++;
                    if (sb_q.size() == 0) ccmp("sb_underflow", 32'(1), 32'(0));
                    else ccmp("sb_sum", 32'(out_sum), 32'(sb_q.pop_front()));
                end
                if (in_valid && in_ready) begin
                    acc_obs++;
                    sb_q.push_back(W'(in_a) + (W+1)'(in_b));
                end
            end
        end
    end

    // ---------------- directed stimulus and literal checks ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    task automatic dcmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out, got no response, expected a handshake", nm);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            in_valid = 1'b0;
            timeout("send");
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk);
            if (out_valid) n = i;
        end
        if (n == 0) timeout("wait_valid");
    endtask

    task automatic pop();
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; fault = 1'b0; fault_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        dcmp("reset_in_ready_low", 32'(in_ready), 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        dcmp("reset_in_ready", 32'(in_ready), 32'h1);
        dcmp("reset_adder_in", 32'(adder_in), 32'h0);
        dcmp("reset_out_sum",  32'(out_sum),  32'h0);

        // carry ripple through all twelve bits
        send(12'hFFF, 12'h001);
        dcmp("ripple_adder_in", 32'(adder_in), 32'h555557);
        wait_valid(lat);
        dcmp("ripple_latency", 32'(lat), 32'(S + 1));
        dcmp("ripple_sum", 32'(out_sum), 32'h1000);
        dcmp("ripple_mismatch", 32'(out_mismatch), 32'h0);
        pop();

        // interleave endpoints, then backpressure and same-edge accept
        send(12'h001, 12'h800);
        dcmp("interleave_bus", 32'(adder_in), 32'h800001);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dcmp("bp_valid", 32'(out_valid), 32'h1);
            dcmp("bp_sum", 32'(out_sum), 32'h801);
            dcmp("bp_in_ready", 32'(in_ready), 32'h0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_a = 12'h123; in_b = 12'h456;
        @(negedge clk);
        dcmp("b2b_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        wait_valid(lat);
        dcmp("b2b_latency", 32'(lat), 32'(S + 1));
        dcmp("b2b_sum", 32'(out_sum), 32'h579);
        pop();

        // fault injection and counter saturation
        fault = 1'b1; fault_val = 13'h0000;
        send(12'h0FF, 12'h001);
        wait_valid(lat);
        dcmp("fault_mismatch", 32'(out_mismatch), 32'h1);
        dcmp("fault_err1", 32'(err_count), 32'h1);
        pop();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) send(W'(i + 1), 12'h001);
        repeat (6) @(posedge clk);
        #1; out_ready = 1'b0; fault = 1'b0;
        @(negedge clk);
        dcmp("err_saturated", 32'(err_count), 32'hFF);

        // reset one edge after accept drops the transaction
        send(12'h0AA, 12'h055);
        rst_n = 1'b0;
        @(negedge clk);
        dcmp("rst_mid_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        dcmp("rst_rel_in_ready", 32'(in_ready), 32'h1);
        dcmp("rst_rel_adder_in", 32'(adder_in), 32'h0);
        dcmp("rst_rel_err", 32'(err_count), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dcmp("rst_no_valid", 32'(out_valid), 32'h0);
        end

        // randomized run against the behavioural netlist
        @(posedge clk); #1;
        sb_on = 1'b1;
        for (int cyc = 0; cyc < 60000 && acc_obs < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 4) != 0);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            out_ready = ($urandom_range(0, 4) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        sb_on = 1'b0;
        dcmp("rand_accepted", 32'(acc_obs >= 10000), 32'h1);
        dcmp("rand_no_loss", 32'(del_obs), 32'(acc_obs));
        dcmp("rand_queue_empty", 32'(sb_q.size()), 32'h0);
        dcmp("rand_err_zero", 32'(err_count), 32'h0);

        n_checks += c_checks;
        n_fail   += c_fail;
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
